// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite responder over a bank of NUM_REGS 32-bit registers
// Independent AW/W holding slots feed one commit; the read path answers from the pre-commit bank.
module axi_lite_reg_slave #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic [31:0]      r_regs [NUM_REGS];
  logic             r_aw_full;
  logic [31:0]      r_aw_addr;
  logic             r_w_full;
  logic [31:0]      r_w_data;
  logic [3:0]       r_w_strb;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  logic             w_awready;
  logic             w_wready;
  logic             w_arready;
  logic             w_commit;
  logic [31:0]      w_aw_word;
  logic [31:0]      w_ar_word;
  logic             w_aw_ok;
  logic             w_ar_ok;
  logic [IDX_W-1:0] w_aw_idx;
  logic [IDX_W-1:0] w_ar_idx;

  assign w_awready = rst_n & ~r_aw_full & ~r_bvalid;
  assign w_wready  = rst_n & ~r_w_full & ~r_bvalid;
  assign w_arready = rst_n & ~r_rvalid;
  assign w_commit  = r_aw_full & r_w_full;

  // Whole-word compare so any address beyond the bank, however large, is rejected.
  assign w_aw_word = r_aw_addr >> 2;
  assign w_ar_word = araddr >> 2;
  assign w_aw_ok   = (w_aw_word < NUM_REGS);
  assign w_ar_ok   = (w_ar_word < NUM_REGS);
  assign w_aw_idx  = w_aw_word[IDX_W-1:0];
  assign w_ar_idx  = w_ar_word[IDX_W-1:0];

  assign awready = w_awready;
  assign wready  = w_wready;
  assign arready = w_arready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_aw_ok ? OKAY : SLVERR;
    end else begin
      if (awvalid && w_awready) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= awaddr;
      end
      if (wvalid && w_wready) begin
        r_w_full <= 1'b1;
        r_w_data <= wdata;
        r_w_strb <= wstrb;
      end
      if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_commit && w_aw_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (r_w_strb[b]) begin
          r_regs[w_aw_idx][8*b +: 8] <= r_w_data[8*b +: 8];
        end
      end
    end
  end

  // Sampling r_regs here on a commit edge yields the pre-write value by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (arvalid && w_arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_ok ? r_regs[w_ar_idx] : 32'h0000_0000;
      r_rresp  <= w_ar_ok ? OKAY : SLVERR;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb/tb_axi_lite_reg_slave.sv - directed self-checking bench for axi_lite_reg_slave
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi_lite_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_regs [16];

  always #5 clk = ~clk;

  axi_lite_reg_slave #(.NUM_REGS(16), .RESET_VAL(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit timed_out);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step(); n++;
      if (aw_hs) begin aw_done = 1; awvalid = 0; end
      if (w_hs)  begin w_done = 1;  wvalid = 0;  end
    end
    while (!bvalid && n < 20) begin step(); n++; end
    timed_out = !bvalid;
    resp = bresp;
    awvalid = 0; wvalid = 0;
    step();
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output bit timed_out);
    int n;
    n = 0;
    araddr = a; arvalid = 1; rready = 1;
    while (!arready && n < 20) begin step(); n++; end
    step();
    arvalid = 0;
    timed_out = !rvalid;
    d = rdata;
    resp = rresp;
    step();
    rready = 0;
  endtask

  task automatic note_timeout(input string name, input bit t);
    if (t) begin
      errors++;
      $display("FAIL %s: handshake timed out", name);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit t;
    rst_n = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    step(); step();
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_readies_low: got %b want 000", {awready, wready, arready});
    end
    rst_n = 1;
    step();
    checks++;
    if ({bvalid, rvalid, bresp, rresp, rdata} !== 38'h0) begin
      errors++; $display("FAIL reset_outputs: bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h want all 0",
                         bvalid, rvalid, bresp, rresp, rdata);
    end
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL idle_readies: got %b want 111", {awready, wready, arready});
    end
    do_read(32'h0, d, r, t);
    checks++;
    note_timeout("reset_read", t);
    if (!t && (d !== 32'h0 || r !== 2'b00)) begin
      errors++; $display("FAIL reset_read: got %h/%b want 00000000/00", d, r);
    end
  endtask

  task automatic test_aligned_write();
    logic [31:0] d; logic [1:0] r; bit t;
    awaddr = 32'h8; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    checks++;
    if (!(awready && wready)) begin
      errors++; $display("FAIL aw_w_ready: got %b%b want 11", awready, wready);
    end
    step();
    awvalid = 0; wvalid = 0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL b_latency_early: bvalid=%b want 0 one edge after handshake", bvalid);
    end
    step();
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL b_latency: bvalid=%b bresp=%b want 1/00", bvalid, bresp);
    end
    bready = 1;
    step();
    bready = 0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL b_clear: bvalid=%b want 0", bvalid);
    end
    exp_regs[2] = 32'h1234_5678;
    do_read(32'h8, d, r, t);
    checks++;
    note_timeout("aligned_readback", t);
    if (!t && (d !== 32'h1234_5678 || r !== 2'b00)) begin
      errors++; $display("FAIL aligned_readback: got %h/%b want 12345678/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; bit t;
    int b_count;
    do_write(32'h4, 32'h1122_3344, 4'hF, r, t);
    note_timeout("wfirst_preload", t);
    wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1;
    step();
    wvalid = 0;
    b_count = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wready !== 1'b0 || bvalid !== 1'b0) begin
        errors++; $display("FAIL wfirst_hold: cycle %0d wready=%b bvalid=%b want 0/0", i, wready, bvalid);
      end
      step();
    end
    awaddr = 32'h4; awvalid = 1; bready = 1;
    step();
    awvalid = 0;
    for (int i = 0; i < 6; i++) begin
      if (bvalid) b_count++;
      step();
    end
    bready = 0;
    checks++;
    if (b_count != 1) begin
      errors++; $display("FAIL wfirst_single_b: got %0d responses want 1", b_count);
    end
    exp_regs[1] = 32'h11BB_33DD;
    do_read(32'h4, d, r, t);
    checks++;
    note_timeout("wfirst_readback", t);
    if (!t && d !== 32'h11BB_33DD) begin
      errors++; $display("FAIL wfirst_readback: got %h want 11bb33dd", d);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r; bit t;
    for (int i = 0; i < 16; i++) begin
      do_write(32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, r, t);
      note_timeout("slverr_fill", t);
      exp_regs[i] = 32'hA500_0000 | 32'(i);
    end
    do_write(32'h40, 32'hFFFF_FFFF, 4'hF, r, t);
    checks++;
    note_timeout("slverr_write", t);
    if (!t && r !== 2'b10) begin
      errors++; $display("FAIL slverr_bresp: got %b want 10", r);
    end
    do_read(32'h40, d, r, t);
    checks++;
    note_timeout("slverr_read", t);
    if (!t && (r !== 2'b10 || d !== 32'h0)) begin
      errors++; $display("FAIL slverr_read: got %h/%b want 00000000/10", d, r);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(32'(i * 4), d, r, t);
      checks++;
      note_timeout("slverr_bank", t);
      if (!t && (d !== exp_regs[i] || r !== 2'b00)) begin
        errors++; $display("FAIL slverr_bank[%0d]: got %h/%b want %h/00", i, d, r, exp_regs[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    awaddr = 32'hC; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    step();
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 10) begin step(); n++; end
    exp_regs[3] = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++; $display("FAIL b_stall[%0d]: bvalid=%b bresp=%b awready=%b wready=%b want 1/00/0/0",
                           i, bvalid, bresp, awready, wready);
      end
      step();
    end
    bready = 1;
    step();
    bready = 0;
    araddr = 32'hC; arvalid = 1; rready = 0;
    step();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hCAFE_F00D || rresp !== 2'b00 || arready !== 1'b0) begin
        errors++; $display("FAIL r_stall[%0d]: rvalid=%b rdata=%h rresp=%b arready=%b want 1/cafef00d/00/0",
                           i, rvalid, rdata, rresp, arready);
      end
      step();
    end
    rready = 1;
    step();
    rready = 0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++; $display("FAIL r_release: rvalid=%b arready=%b want 0/1", rvalid, arready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit t;
    int b_seen;
    awaddr = 32'h10; awvalid = 1; wvalid = 0; bready = 1;
    step();
    rst_n = 0;
    #1;
    checks++;
    if (awready !== 1'b0) begin
      errors++; $display("FAIL midreset_awready: got %b want 0", awready);
    end
    step();
    awvalid = 0;
    rst_n = 1;
    b_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid) b_seen++;
      step();
    end
    bready = 0;
    checks++;
    if (b_seen != 0) begin
      errors++; $display("FAIL midreset_no_b: got %0d responses want 0", b_seen);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(32'(i * 4), d, r, t);
      checks++;
      note_timeout("midreset_bank", t);
      if (!t && d !== 32'h0) begin
        errors++; $display("FAIL midreset_bank[%0d]: got %h want 00000000", i, d);
      end
    end
    do_write(32'h10, 32'h5A5A_5A5A, 4'hF, r, t);
    checks++;
    note_timeout("midreset_fresh", t);
    if (!t && r !== 2'b00) begin
      errors++; $display("FAIL midreset_fresh_bresp: got %b want 00", r);
    end
    do_read(32'h10, d, r, t);
    checks++;
    note_timeout("midreset_fresh_read", t);
    if (!t && d !== 32'h5A5A_5A5A) begin
      errors++; $display("FAIL midreset_fresh_read: got %h want 5a5a5a5a", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; bit t;
    awaddr = 32'h14; wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    step();
    awvalid = 0; wvalid = 0;
    araddr = 32'h14; arvalid = 1; rready = 0;
    step();
    arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0 || bvalid !== 1'b1) begin
      errors++; $display("FAIL collision_old: rvalid=%b rdata=%h bvalid=%b want 1/00000000/1",
                         rvalid, rdata, bvalid);
    end
    rready = 1;
    step();
    rready = 0; bready = 0;
    do_read(32'h14, d, r, t);
    checks++;
    note_timeout("collision_new", t);
    if (!t && d !== 32'h0000_0077) begin
      errors++; $display("FAIL collision_new: got %h want 00000077", d);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    test_reset();
    test_aligned_write();
    test_w_before_aw();
    test_slverr();
    test_backpressure();
    test_reset_mid();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
